// File: rtl/shift_and_subtract_binary_divider.sv
// shift_and_subtract_binary_divider: sequential restoring unsigned divider, one quotient bit per clock MSB first.
module shift_and_subtract_binary_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]    r_state;
  logic [DW-1:0] r_dq;
  logic [VW-1:0] r_dv;
  logic [VW:0]   r_rem;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;
  logic          r_dbz;
  logic [VW:0]   w_t;
  logic          w_ge;
  logic [VW:0]   w_rem;
  logic [DW-1:0] w_dq;
  logic          w_zero;
  logic [VW-1:0] w_rz;
  assign w_t    = {r_rem[VW-1:0], r_dq[DW-1]};
  assign w_ge   = w_t >= {1'b0, r_dv};
  assign w_rem  = w_ge ? w_t - {1'b0, r_dv} : w_t;
  assign w_dq   = {r_dq[DW-2:0], w_ge};
  assign w_zero = r_dv == '0;
  assign w_rz   = (DW >= VW) ? VW'(r_dq) : '0;
  // A zero divisor spends a single idle pass through RUN so its result lands two edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dq        <= '0;
      r_dv        <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_dq    <= dividend;
          r_dv    <= divisor;
          r_rem   <= '0;
          r_cnt   <= (divisor == '0) ? '0 : CW'(DW - 1);
          r_dbz   <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (!w_zero) begin
            r_dq  <= w_dq;
            r_rem <= w_rem;
          end
          if (r_cnt == '0) begin
            r_quotient  <= w_zero ? '1 : w_dq;
            r_remainder <= w_zero ? w_rz : w_rem[VW-1:0];
            r_dbz       <= w_zero;
            r_state     <= S_DONE;
          end else r_cnt <= r_cnt - CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy        = r_state != S_IDLE;
  assign done        = r_state == S_DONE;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// tb_shift_and_subtract_binary_divider: directed and random divides checked against an arithmetic reference model.
module tb_shift_and_subtract_binary_divider;
  localparam int DW = 16;
  localparam int VW = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  int errors = 0;
  int checks = 0;
  shift_and_subtract_binary_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  // Reference model: tracks the outstanding request and the edges left until its result appears.
  logic          m_busy, m_done, m_dbz, p_dbz;
  int            m_left;
  logic [DW-1:0] m_q, p_q;
  logic [VW-1:0] m_r, p_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_q <= '0; m_r <= '0; m_dbz <= 1'b0;
      p_q <= '0; p_r <= '0; p_dbz <= 1'b0;
    end else if (m_done) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dbz <= p_dbz;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_dbz  <= 1'b0;
      m_left <= (divisor == 0) ? 1 : DW;
      p_dbz  <= divisor == 0;
      p_q    <= (divisor == 0) ? {DW{1'b1}} : DW'(int'(dividend) / int'(divisor));
      p_r    <= (divisor == 0) ? dividend[VW-1:0] : VW'(int'(dividend) % int'(divisor));
    end
  end
  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic [DW-1:0] eq,
                     input logic [VW-1:0] er, input logic ed);
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
    wait_done(lat);
    chk("latency", 32'(lat), (b == 0) ? 32'd2 : 32'(DW + 1));
    chk("q_lit", 32'(quotient), 32'(eq));
    chk("r_lit", 32'(remainder), 32'(er));
    chk("dbz_lit", 32'(div_by_zero), 32'(ed));
  endtask
  initial begin
    int lat;
    int dones;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    rst_n = 1'b1;
    run(16'd100, 8'd7, 16'd14, 8'd2, 1'b0);
    run(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
    run(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
    run(16'd5, 8'd10, 16'd0, 8'd5, 1'b0);
    run(16'd0, 8'd9, 16'd0, 8'd0, 1'b0);
    run(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
    run(16'd8, 8'd2, 16'd4, 8'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd99; divisor = 8'd4;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("ignored_start_dones", 32'(dones), 1);
    chk("ignored_start_q", 32'(quotient), 32'd16);
    chk("ignored_start_r", 32'(remainder), 32'd2);
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q", 32'(quotient), 0);
    chk("abort_r", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(16'd200, 8'd13, 16'd15, 8'd5, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      a = DW'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : VW'($urandom);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
      wait_done(lat);
      chk("rand_done", 32'(done), 1);
      if (b != 0) chk("rand_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
